// File: rtl/ex_mem_sched_pkg.sv
// Shared definitions for the EX-stage memory-port scheduler: pipeline stall
// bus layout, lane limits and lane field slicing helpers.
package ex_mem_sched_pkg;

  localparam int STALL_W = 6;
  localparam int STALL_EX = 3;
  localparam int STALL_MEM = 4;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int MEM_LANES_MAX = 8;
  localparam int LANE_IDX_W = $clog2(MEM_LANES_MAX);

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_SERIAL
  } sched_state_e;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // Low bit of a lane's field inside a flattened per-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ex_mem_sched_lane_prio_enc.sv
// Lowest-lane-first priority encoder over a pending mask, giving both the
// binary lane index and the isolated one-hot bit.
module lane_prio_enc
  import ex_mem_sched_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]      pend,
  output logic [LANE_IDX_W-1:0] sel,
  output logic [LANES-1:0]      onehot
);

  always_comb begin
    sel = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend[i]) sel = LANE_IDX_W'(i);
    end
    onehot = pend & (~pend + LANES'(1));
  end

endmodule

// File: rtl/ex_mem_sched.sv
// Memory-port scheduler for the N-issue EX stage: holds the bundle's memory
// fields and drains pending lanes onto the single data-SRAM port, lowest first.
module ex_mem_sched
  import ex_mem_sched_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [STALL_W-1:0]               stall,
  output logic                             stallreq_for_mem,
  input  logic [LANES-1:0]                 in_valid,
  input  logic [LANES*be_width(DATA_W)-1:0] in_wen,
  input  logic [LANES*ADDR_W-1:0]          in_addr,
  input  logic [LANES*DATA_W-1:0]          in_wdata,
  output logic                             data_sram_en,
  output logic [be_width(DATA_W)-1:0]      data_sram_wen,
  output logic [ADDR_W-1:0]                data_sram_addr,
  output logic [DATA_W-1:0]                data_sram_wdata,
  output logic [LANES-1:0]                 mem_lane_oh,
  output logic [15:0]                      serial_cycles
);

  localparam int BE_W = be_width(DATA_W);

  logic [LANES-1:0]        pend;
  logic [LANES*BE_W-1:0]   wen_q;
  logic [LANES*ADDR_W-1:0] addr_q;
  logic [LANES*DATA_W-1:0] wdata_q;

  logic [LANE_IDX_W-1:0]   sel;
  logic [LANES-1:0]        sel_oh;
  logic [LANES-1:0]        rest;
  logic                    issue;
  sched_state_e            state;

  logic                    unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

  lane_prio_enc #(
    .LANES(LANES)
  ) u_prio (
    .pend   (pend),
    .sel    (sel),
    .onehot (sel_oh)
  );

  // The scheduler state is a pure decode of the pending mask; stallreq is
  // taken from it so no combinational path exists from stall or flush.
  always_comb begin
    state = SCHED_IDLE;
    if ($countones(pend) >= 2) state = SCHED_SERIAL;
    else if (pend != '0) state = SCHED_ISSUE;
    stallreq_for_mem = (state == SCHED_SERIAL);
  end

  always_comb begin
    issue = (pend != '0) && !flush && (stall[STALL_MEM] == NO_STOP);
    rest  = pend & ~(issue ? sel_oh : '0);
    data_sram_en    = issue;
    data_sram_wen   = issue ? wen_q[lane_lo(int'(sel), BE_W) +: BE_W] : '0;
    data_sram_addr  = addr_q[lane_lo(int'(sel), ADDR_W) +: ADDR_W];
    data_sram_wdata = wdata_q[lane_lo(int'(sel), DATA_W) +: DATA_W];
    mem_lane_oh     = issue ? sel_oh : '0;
  end

  // A bundle still draining blocks new loads; only once the last lane goes
  // out (or nothing was pending) may EX hand over the next bundle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend    <= '0;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (rest != '0) begin
      pend <= rest;
    end else if (stall[STALL_EX] == NO_STOP) begin
      pend    <= in_valid;
      wen_q   <= in_wen;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      pend <= '0;
    end
  end

  // Serialisation counter survives flushes so it measures total lost cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      serial_cycles <= '0;
    end else if (stallreq_for_mem && serial_cycles != 16'hFFFF) begin
      serial_cycles <= serial_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_sched.sv
// Self-checking bench for ex_mem_sched with four lanes: directed scenarios
// plus randomized traffic compared against a queue-based reference model.
module tb_ex_mem_sched;

  localparam int LANES = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [5:0]   stall;
  logic         stallreq_for_mem;
  logic [3:0]   in_valid;
  logic [15:0]  in_wen;
  logic [127:0] in_addr;
  logic [127:0] in_wdata;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [3:0]   mem_lane_oh;
  logic [15:0]  serial_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending lane numbers plus the latched bundle.
  int          q[$];
  logic [3:0]  m_wen[4];
  logic [31:0] m_addr[4];
  logic [31:0] m_wdata[4];
  int          m_cnt;

  ex_mem_sched #(
    .LANES(LANES),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .stall            (stall),
    .stallreq_for_mem (stallreq_for_mem),
    .in_valid         (in_valid),
    .in_wen           (in_wen),
    .in_addr          (in_addr),
    .in_wdata         (in_wdata),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .mem_lane_oh      (mem_lane_oh),
    .serial_cycles    (serial_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_lane(input int l, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    in_wen[l*4 +: 4]     = w;
    in_addr[l*32 +: 32]  = a;
    in_wdata[l*32 +: 32] = d;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_wen   = '0;
    in_addr  = '0;
    in_wdata = '0;
    flush    = 1'b0;
    stall    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt = 0;
    for (int l = 0; l < 4; l++) begin
      m_wen[l] = '0;
      m_addr[l] = '0;
      m_wdata[l] = '0;
    end
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_advance();
    bit go;
    go = (q.size() > 0) && !flush && !stall[4];
    if (rst) m_cnt = 0;
    else if (q.size() >= 2 && m_cnt < 65535) m_cnt++;
    if (rst || flush) begin
      q.delete();
      for (int l = 0; l < 4; l++) begin
        m_wen[l] = '0;
        m_addr[l] = '0;
        m_wdata[l] = '0;
      end
    end else begin
      if (go) void'(q.pop_front());
      if (q.size() == 0) begin
        if (!stall[3]) begin
          for (int l = 0; l < 4; l++) begin
            if (in_valid[l]) q.push_back(l);
            m_wen[l]   = in_wen[l*4 +: 4];
            m_addr[l]  = in_addr[l*32 +: 32];
            m_wdata[l] = in_wdata[l*32 +: 32];
          end
        end else if (!stall[4]) begin
          q.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    in_valid = 4'b1111;
    set_lane(0, 4'hF, 32'h1234, 32'h5678);
    tick();
    rst = 1'b0;
    in_valid = '0;
    #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en got %b want 0", data_sram_en); end
    checks++; if (data_sram_wen !== 4'h0) begin errors++; $display("[TB] FAIL reset_wen got %h want 0", data_sram_wen); end
    checks++; if (data_sram_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", data_sram_addr); end
    checks++; if (data_sram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata got %h want 0", data_sram_wdata); end
    checks++; if (mem_lane_oh !== 4'h0) begin errors++; $display("[TB] FAIL reset_oh got %b want 0", mem_lane_oh); end
    checks++; if (stallreq_for_mem !== 1'b0) begin errors++; $display("[TB] FAIL reset_stallreq got %b want 0", stallreq_for_mem); end
    checks++; if (serial_cycles !== 16'h0) begin errors++; $display("[TB] FAIL reset_count got %h want 0", serial_cycles); end
  endtask

  task automatic test_single_load();
    do_reset();
    set_lane(1, 4'h0, 32'h1000, 32'h55);
    in_valid = 4'b0010;
    #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL single_latency got %b want 0", data_sram_en); end
    tick();
    in_valid = '0;
    #1;
    checks++; if (data_sram_en !== 1'b1) begin errors++; $display("[TB] FAIL single_en got %b want 1", data_sram_en); end
    checks++; if (data_sram_wen !== 4'h0) begin errors++; $display("[TB] FAIL single_wen got %h want 0", data_sram_wen); end
    checks++; if (data_sram_addr !== 32'h1000) begin errors++; $display("[TB] FAIL single_addr got %h want 1000", data_sram_addr); end
    checks++; if (mem_lane_oh !== 4'b0010) begin errors++; $display("[TB] FAIL single_oh got %b want 0010", mem_lane_oh); end
    checks++; if (stallreq_for_mem !== 1'b0) begin errors++; $display("[TB] FAIL single_stallreq got %b want 0", stallreq_for_mem); end
    tick();
    #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL single_after got %b want 0", data_sram_en); end
  endtask

  task automatic test_dual_op();
    do_reset();
    set_lane(0, 4'hF, 32'h2000, 32'hDEADBEEF);
    set_lane(1, 4'h0, 32'h2004, 32'h1111);
    in_valid = 4'b0011;
    tick();
    set_lane(1, 4'h0, 32'hBAD4, 32'h0);
    set_lane(2, 4'h0, 32'h3000, 32'h0);
    in_valid = 4'b0100;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'hF) begin errors++; $display("[TB] FAIL dual_c1_store got en=%b wen=%h want en=1 wen=f", data_sram_en, data_sram_wen); end
    checks++; if (data_sram_addr !== 32'h2000 || data_sram_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL dual_c1_data got %h/%h want 2000/deadbeef", data_sram_addr, data_sram_wdata); end
    checks++; if (mem_lane_oh !== 4'b0001 || stallreq_for_mem !== 1'b1) begin errors++; $display("[TB] FAIL dual_c1_oh got oh=%b sr=%b want 0001/1", mem_lane_oh, stallreq_for_mem); end
    tick();
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'h0 || data_sram_addr !== 32'h2004) begin errors++; $display("[TB] FAIL dual_c2_load got en=%b wen=%h addr=%h want 1/0/2004", data_sram_en, data_sram_wen, data_sram_addr); end
    checks++; if (mem_lane_oh !== 4'b0010 || stallreq_for_mem !== 1'b0) begin errors++; $display("[TB] FAIL dual_c2_oh got oh=%b sr=%b want 0010/0", mem_lane_oh, stallreq_for_mem); end
    checks++; if (serial_cycles !== 16'd1) begin errors++; $display("[TB] FAIL dual_count got %0d want 1", serial_cycles); end
    tick();
    in_valid = '0;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h3000 || mem_lane_oh !== 4'b0100) begin errors++; $display("[TB] FAIL dual_next got en=%b addr=%h oh=%b want 1/3000/0100", data_sram_en, data_sram_addr, mem_lane_oh); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    for (int l = 0; l < 3; l++) set_lane(l, 4'h0, 32'h100 + 32'(4 * l), 32'h0);
    in_valid = 4'b0111;
    tick();
    in_valid = '0;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h100 || stallreq_for_mem !== 1'b1) begin errors++; $display("[TB] FAIL mstall_first got en=%b addr=%h sr=%b want 1/100/1", data_sram_en, data_sram_addr, stallreq_for_mem); end
    tick();
    stall = 6'b010000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (data_sram_en !== 1'b0 || mem_lane_oh !== 4'b0 || data_sram_wen !== 4'h0 || stallreq_for_mem !== 1'b1) begin errors++; $display("[TB] FAIL mstall_hold%0d got en=%b oh=%b sr=%b want 0/0000/1", c, data_sram_en, mem_lane_oh, stallreq_for_mem); end
      tick();
    end
    stall = '0;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h104 || mem_lane_oh !== 4'b0010) begin errors++; $display("[TB] FAIL mstall_resume got en=%b addr=%h oh=%b want 1/104/0010", data_sram_en, data_sram_addr, mem_lane_oh); end
    checks++; if (serial_cycles !== 16'd4) begin errors++; $display("[TB] FAIL mstall_count got %0d want 4", serial_cycles); end
    tick();
    #1;
    checks++; if (data_sram_addr !== 32'h108 || mem_lane_oh !== 4'b0100 || stallreq_for_mem !== 1'b0 || serial_cycles !== 16'd5) begin errors++; $display("[TB] FAIL mstall_last got addr=%h oh=%b sr=%b cnt=%0d want 108/0100/0/5", data_sram_addr, mem_lane_oh, stallreq_for_mem, serial_cycles); end
  endtask

  task automatic test_flush();
    do_reset();
    set_lane(0, 4'hF, 32'h40, 32'hCAFE);
    in_valid = 4'b0001;
    tick();
    set_lane(1, 4'h0, 32'h44, 32'h0);
    in_valid = 4'b0010;
    flush = 1'b1;
    #1;
    checks++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0 || mem_lane_oh !== 4'b0) begin errors++; $display("[TB] FAIL flush_now got en=%b wen=%h oh=%b want 0/0/0000", data_sram_en, data_sram_wen, mem_lane_oh); end
    tick();
    flush = 1'b0;
    in_valid = '0;
    #1;
    checks++; if (data_sram_en !== 1'b0 || stallreq_for_mem !== 1'b0) begin errors++; $display("[TB] FAIL flush_after got en=%b sr=%b want 0/0", data_sram_en, stallreq_for_mem); end
    tick();
    #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_later got en=%b want 0", data_sram_en); end
  endtask

  task automatic test_bubble();
    do_reset();
    stall = 6'b001000;
    set_lane(0, 4'h3, 32'h500, 32'h1);
    set_lane(1, 4'h0, 32'h504, 32'h2);
    in_valid = 4'b0011;
    tick();
    #1;
    checks++; if (data_sram_en !== 1'b0 || stallreq_for_mem !== 1'b0) begin errors++; $display("[TB] FAIL bubble_drop got en=%b sr=%b want 0/0", data_sram_en, stallreq_for_mem); end
    stall = '0;
    in_valid = '0;
    tick();
    #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL bubble_after got en=%b want 0", data_sram_en); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int l = 0; l < 4; l++) set_lane(l, 4'h0, 32'h10 + 32'(4 * l), 32'h0);
    in_valid = 4'b1011;
    tick();
    in_valid = '0;
    #1;
    checks++; if (data_sram_addr !== 32'h10 || mem_lane_oh !== 4'b0001 || stallreq_for_mem !== 1'b1) begin errors++; $display("[TB] FAIL b2b_c1 got addr=%h oh=%b sr=%b want 10/0001/1", data_sram_addr, mem_lane_oh, stallreq_for_mem); end
    tick();
    set_lane(2, 4'h1, 32'h20, 32'h77);
    in_valid = 4'b0100;
    #1;
    checks++; if (data_sram_addr !== 32'h14 || mem_lane_oh !== 4'b0010 || stallreq_for_mem !== 1'b1) begin errors++; $display("[TB] FAIL b2b_c2 got addr=%h oh=%b sr=%b want 14/0010/1", data_sram_addr, mem_lane_oh, stallreq_for_mem); end
    tick();
    #1;
    checks++; if (data_sram_addr !== 32'h1C || mem_lane_oh !== 4'b1000 || stallreq_for_mem !== 1'b0 || serial_cycles !== 16'd2) begin errors++; $display("[TB] FAIL b2b_c3 got addr=%h oh=%b sr=%b cnt=%0d want 1c/1000/0/2", data_sram_addr, mem_lane_oh, stallreq_for_mem, serial_cycles); end
    tick();
    in_valid = '0;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h20 || data_sram_wen !== 4'h1 || mem_lane_oh !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_next got en=%b addr=%h wen=%h oh=%b want 1/20/1/0100", data_sram_en, data_sram_addr, data_sram_wen, mem_lane_oh); end
    tick();
    #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got en=%b want 0", data_sram_en); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int l = 0; l < 4; l++) set_lane(l, 4'hF, 32'h600 + 32'(4 * l), 32'h9);
    in_valid = 4'b1111;
    tick();
    in_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (data_sram_en !== 1'b0 || stallreq_for_mem !== 1'b0 || serial_cycles !== 16'd0) begin errors++; $display("[TB] FAIL rstdrain got en=%b sr=%b cnt=%0d want 0/0/0", data_sram_en, stallreq_for_mem, serial_cycles); end
    tick();
    #1;
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL rstdrain_later got en=%b want 0", data_sram_en); end
  endtask

  task automatic test_random();
    bit          e_en;
    int          lane;
    logic [3:0]  e_oh;
    do_reset();
    model_clear();
    for (int c = 0; c < 400; c++) begin
      in_valid = 4'($urandom);
      in_wen   = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom);
      in_addr  = {$urandom, $urandom, $urandom, $urandom};
      in_wdata = {$urandom, $urandom, $urandom, $urandom};
      stall    = 6'($urandom);
      stall[4] = ($urandom_range(3) == 0);
      stall[3] = ($urandom_range(3) == 0);
      flush    = ($urandom_range(15) == 0);
      rst      = ($urandom_range(31) == 0);
      #1;
      e_en = (q.size() > 0) && !flush && !stall[4];
      lane = (q.size() > 0) ? q[0] : 0;
      e_oh = e_en ? 4'(1 << lane) : 4'h0;
      checks++; if (data_sram_en !== e_en) begin errors++; $display("[TB] FAIL rnd_en c%0d got %b want %b", c, data_sram_en, e_en); end
      checks++; if (mem_lane_oh !== e_oh) begin errors++; $display("[TB] FAIL rnd_oh c%0d got %b want %b", c, mem_lane_oh, e_oh); end
      checks++; if (data_sram_wen !== (e_en ? m_wen[lane] : 4'h0)) begin errors++; $display("[TB] FAIL rnd_wen c%0d got %h want %h", c, data_sram_wen, e_en ? m_wen[lane] : 4'h0); end
      checks++; if (stallreq_for_mem !== (q.size() >= 2)) begin errors++; $display("[TB] FAIL rnd_stallreq c%0d got %b want %b", c, stallreq_for_mem, q.size() >= 2); end
      checks++; if (serial_cycles !== 16'(m_cnt)) begin errors++; $display("[TB] FAIL rnd_count c%0d got %0d want %0d", c, serial_cycles, m_cnt); end
      if (e_en) begin
        checks++; if (data_sram_addr !== m_addr[lane] || data_sram_wdata !== m_wdata[lane]) begin errors++; $display("[TB] FAIL rnd_data c%0d got %h/%h want %h/%h", c, data_sram_addr, data_sram_wdata, m_addr[lane], m_wdata[lane]); end
      end
      @(posedge clk);
      model_advance();
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    set_lane(0, 4'h0, 32'h700, 32'h0);
    set_lane(1, 4'h0, 32'h704, 32'h0);
    in_valid = 4'b0011;
    tick();
    in_valid = '0;
    stall = 6'b010000;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (serial_cycles !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_pre got %h want fffe", serial_cycles); end
    tick();
    #1;
    checks++; if (serial_cycles !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_top got %h want ffff", serial_cycles); end
    tick();
    #1;
    checks++; if (serial_cycles !== 16'hFFFF || stallreq_for_mem !== 1'b1) begin errors++; $display("[TB] FAIL sat_hold got cnt=%h sr=%b want ffff/1", serial_cycles, stallreq_for_mem); end
    stall = '0;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h700) begin errors++; $display("[TB] FAIL sat_release got en=%b addr=%h want 1/700", data_sram_en, data_sram_addr); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_load();
    test_dual_op();
    test_mem_stall();
    test_flush();
    test_bubble();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
